// File: rtl/vec16_pkg.sv
// Shared constants and types for the 16-word result serializer and its
// future input-side counterpart.
package vec16_pkg;
    localparam int WIDTH = 32;
    localparam int N     = 16;
    localparam int IDX_W = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic TAG_FLOAT  = 1'b0;
    localparam logic TAG_SIGNED = 1'b1;
endpackage

// File: rtl/vec16_serializer_if.sv
// Parallel-load / serial valid-ready bus between the result select bank and
// the 32-bit consumer.
interface vec16_serializer_if;
    import vec16_pkg::*;

    logic [N*WIDTH-1:0] in_vec;
    logic               in_sel;
    logic               load;
    logic               load_ready;
    logic               abort;
    logic [WIDTH-1:0]   out_data;
    logic               out_tag;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               overrun;
    logic               overrun_clr;

    modport master (
        output in_vec, in_sel, load, abort, out_ready, overrun_clr,
        input  load_ready, out_data, out_tag, out_valid, out_last, overrun
    );

    modport slave (
        input  in_vec, in_sel, load, abort, out_ready, overrun_clr,
        output load_ready, out_data, out_tag, out_valid, out_last, overrun
    );
endinterface

// File: rtl/vec16_frame_reg.sv
// N x WIDTH capture register: parallel load in one cycle, one word read out
// through an index port.
module vec16_frame_reg #(
    parameter int WIDTH = 32,
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic [N*WIDTH-1:0] i_vec,
    input  logic [IDX_W-1:0]   i_idx,
    output logic [WIDTH-1:0]   o_word
);
    logic [WIDTH-1:0] r_word [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) r_word[k] <= '0;
        end else if (i_load) begin
            for (int k = 0; k < N; k++) r_word[k] <= i_vec[k*WIDTH +: WIDTH];
        end
    end

    assign o_word = r_word[i_idx];
endmodule

// File: rtl/vec16_serializer.sv
// Captures a 16-word result frame plus its select tag and streams it out one
// word per beat with a last marker; abort flushes, overrun flags dropped loads.
module vec16_serializer #(
    parameter int WIDTH = vec16_pkg::WIDTH,
    parameter int N     = vec16_pkg::N
) (
    input  logic              clk,
    input  logic              rst_n,
    vec16_serializer_if.slave bus
);
    import vec16_pkg::*;

    localparam int               LIDX_W   = $clog2(N);
    localparam logic [LIDX_W-1:0] IDX_LAST = LIDX_W'(N - 1);

    state_t              r_state;
    state_t              w_next;
    logic [LIDX_W-1:0]   r_idx;
    logic                r_tag;
    logic                r_overrun;
    logic                w_capture;
    logic                w_advance;
    logic                w_ovr_set;
    logic [WIDTH-1:0]    w_word;

    vec16_frame_reg #(
        .WIDTH (WIDTH),
        .N     (N),
        .IDX_W (LIDX_W)
    ) u_frame (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_capture),
        .i_vec  (bus.in_vec),
        .i_idx  (r_idx),
        .o_word (w_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Abort outranks everything: it cancels the pending beat, a capture and an overrun.
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_advance = 1'b0;
        w_ovr_set = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.load && !bus.abort) begin
                    w_capture = 1'b1;
                    w_next    = SEND;
                end
            end
            SEND: begin
                if (bus.abort) begin
                    w_next = IDLE;
                end else begin
                    w_ovr_set = bus.load;
                    if (bus.out_ready) begin
                        w_advance = 1'b1;
                        if (r_idx == IDX_LAST) w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_capture || bus.abort) begin
            r_idx <= '0;
        end else if (w_advance) begin
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + LIDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_tag <= TAG_FLOAT;
        else if (w_capture) r_tag <= bus.in_sel;
    end

    // Set beats clear when both land in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               r_overrun <= 1'b0;
        else if (w_ovr_set)       r_overrun <= 1'b1;
        else if (bus.overrun_clr) r_overrun <= 1'b0;
    end

    assign bus.out_valid  = (r_state == SEND);
    assign bus.load_ready = (r_state == IDLE);
    assign bus.out_last   = (r_state == SEND) && (r_idx == IDX_LAST);
    assign bus.out_data   = w_word;
    assign bus.out_tag    = r_tag;
    assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_vec16_serializer.sv
// Scoreboard bench for vec16_serializer: loads push expected beats, a negedge
// monitor pops and compares every delivered beat and checks stall stability.
module tb_vec16_serializer;
    localparam int W = 32;
    localparam int N = 16;

    typedef struct packed {
        logic [W-1:0] d;
        logic         t;
        logic         l;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   beats;
    exp_t exp_q[$];

    vec16_serializer_if ifc();

    vec16_serializer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [N*W-1:0] build(input logic [W-1:0] base, input logic [W-1:0] step);
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = base + step * W'(k);
        return v;
    endfunction

    // Monitor: a beat is delivered only when valid, ready, not aborted, out of reset.
    always @(negedge clk) begin
        if (rst_n && ifc.out_valid && !ifc.abort) begin
            if (ifc.out_ready) begin
                exp_t e;
                beats++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", ifc.out_data, e.d);
                    chk("beat_tag", {31'd0, ifc.out_tag}, {31'd0, e.t});
                    chk("beat_last", {31'd0, ifc.out_last}, {31'd0, e.l});
                end
            end else if (exp_q.size() > 0) begin
                chk("stall_data", ifc.out_data, exp_q[0].d);
                chk("stall_last", {31'd0, ifc.out_last}, {31'd0, exp_q[0].l});
            end
        end
    end

    task automatic do_load(input logic [N*W-1:0] v, input logic sel);
        @(posedge clk);
        #1;
        chk("load_ready_idle", {31'd0, ifc.load_ready}, 32'd1);
        ifc.in_vec = v;
        ifc.in_sel = sel;
        ifc.load   = 1'b1;
        for (int k = 0; k < N; k++) exp_q.push_back({v[k*W +: W], sel, (k == N-1)});
        @(posedge clk);
        #1;
        ifc.load   = 1'b0;
        ifc.in_vec = ~v;
        ifc.in_sel = ~sel;
        chk("valid_after_load", {31'd0, ifc.out_valid}, 32'd1);
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic pulse_clr();
        ifc.overrun_clr = 1'b1;
        @(posedge clk);
        #1;
        ifc.overrun_clr = 1'b0;
    endtask

    initial begin
        int b0;
        checks = 0;
        errors = 0;
        beats  = 0;
        rst_n           = 1'b0;
        ifc.in_vec      = '0;
        ifc.in_sel      = 1'b0;
        ifc.load        = 1'b0;
        ifc.abort       = 1'b0;
        ifc.out_ready   = 1'b1;
        ifc.overrun_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("rst_last", {31'd0, ifc.out_last}, 32'd0);
        chk("rst_data", ifc.out_data, 32'd0);
        chk("rst_tag", {31'd0, ifc.out_tag}, 32'd0);
        chk("rst_load_ready", {31'd0, ifc.load_ready}, 32'd1);
        chk("rst_overrun", {31'd0, ifc.overrun}, 32'd0);
        rst_n = 1'b1;

        // Full-rate frame
        do_load(build(32'h1000_0000, 32'd1), 1'b1);
        repeat (15) @(posedge clk);
        #1;
        chk("t1_last_on_15", {31'd0, ifc.out_last}, 32'd1);
        chk("t1_busy_on_15", {31'd0, ifc.load_ready}, 32'd0);
        chk("t1_left_on_15", 32'(exp_q.size()), 32'd1);
        @(posedge clk);
        #1;
        chk("t1_all_sent", 32'(exp_q.size()), 32'd0);
        chk("t1_load_ready_after", {31'd0, ifc.load_ready}, 32'd1);
        chk("t1_valid_after", {31'd0, ifc.out_valid}, 32'd0);

        // Stalled frame, ready pattern 1,0,0
        b0 = beats;
        do_load(build(32'h1000_0000, 32'd1), 1'b1);
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            ifc.out_ready = (i % 3 == 0);
            @(posedge clk);
            #1;
        end
        chk("t2_transfers", 32'(beats - b0), 32'd16);
        chk("t2_drained", 32'(exp_q.size()), 32'd0);
        chk("t2_valid_after", {31'd0, ifc.out_valid}, 32'd0);
        exp_q.delete();
        ifc.out_ready = 1'b1;

        // Overrun during frame, then clear, then clear vs set collision
        do_load(build(32'hB000_0000, 32'd3), 1'b0);
        repeat (4) @(posedge clk);
        #1;
        ifc.in_vec = build(32'hDEAD_0000, 32'd1);
        ifc.load   = 1'b1;
        @(posedge clk);
        #1;
        ifc.load = 1'b0;
        chk("t3_overrun_set", {31'd0, ifc.overrun}, 32'd1);
        wait_empty();
        chk("t3_overrun_sticky", {31'd0, ifc.overrun}, 32'd1);
        pulse_clr();
        chk("t3_overrun_cleared", {31'd0, ifc.overrun}, 32'd0);
        do_load(build(32'hC000_0100, 32'h10), 1'b1);
        repeat (2) @(posedge clk);
        #1;
        ifc.load        = 1'b1;
        ifc.overrun_clr = 1'b1;
        @(posedge clk);
        #1;
        ifc.load        = 1'b0;
        ifc.overrun_clr = 1'b0;
        chk("t3_set_beats_clr", {31'd0, ifc.overrun}, 32'd1);
        wait_empty();
        pulse_clr();
        chk("t3_overrun_cleared2", {31'd0, ifc.overrun}, 32'd0);

        // Abort at beat 7 with a concurrent load
        do_load(build(32'hD000_0000, 32'd5), 1'b0);
        repeat (7) @(posedge clk);
        #1;
        ifc.abort  = 1'b1;
        ifc.load   = 1'b1;
        ifc.in_vec = build(32'hEEEE_0000, 32'd1);
        @(posedge clk);
        #1;
        ifc.abort = 1'b0;
        ifc.load  = 1'b0;
        chk("t4_valid_dropped", {31'd0, ifc.out_valid}, 32'd0);
        chk("t4_idle", {31'd0, ifc.load_ready}, 32'd1);
        chk("t4_no_overrun", {31'd0, ifc.overrun}, 32'd0);
        chk("t4_undelivered", 32'(exp_q.size()), 32'd9);
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("t4_no_capture", {31'd0, ifc.out_valid}, 32'd0);
        do_load(build(32'hA000_0000, 32'd7), 1'b1);
        wait_empty();

        // Asynchronous reset mid-frame
        do_load(build(32'h5000_0000, 32'd2), 1'b1);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("t5_async_last", {31'd0, ifc.out_last}, 32'd0);
        chk("t5_async_data", ifc.out_data, 32'd0);
        chk("t5_async_load_ready", {31'd0, ifc.load_ready}, 32'd1);
        exp_q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        b0 = beats;
        do_load(build(32'h6000_00F0, 32'd1), 1'b0);
        wait_empty();
        chk("t5_frame_after_reset", 32'(beats - b0), 32'd16);
        chk("t5_idle_end", {31'd0, ifc.load_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/vec16_serializer.md
# vec16_serializer

Downstream stage of the 16-lane float/signed result select. Captures the 16 selected 32-bit words in one cycle, together with the select value that chose them, and streams them out one word per beat over a valid/ready interface with a last marker. This decouples the wide parallel result bank from the narrow 32-bit consumer (writeback, UART/AXI-stream bridge).

## Interface
Parameters:
- WIDTH, 32, bits per word
- N, 16, words per frame

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_vec  in  N*WIDTH  selected words, word k at bits [k*WIDTH +: WIDTH]
- in_sel  in  1  select value that produced in_vec (0 = float bank, 1 = signed bank)
- load  in  1  request to capture in_vec/in_sel
- load_ready  out  1  high when a load is accepted this cycle
- abort  in  1  synchronous frame flush
- out_data  out  WIDTH  current word
- out_tag  out  1  captured in_sel for the current frame
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts the beat
- out_last  out  1  current beat is word N-1
- overrun  out  1  sticky: load requested while busy
- overrun_clr  in  1  clears overrun

## Operation
- Two states: IDLE, SEND.
- IDLE: load_ready=1, out_valid=0. load=1 and abort=0: capture in_vec into the frame register, in_sel into the tag, set idx=0, go to SEND.
- SEND: out_valid=1, out_data=frame[idx], out_tag=tag, out_last=(idx==N-1). Beat transfers when out_valid and out_ready are both high. On a transfer with idx<N-1, idx increments. On a transfer with idx==N-1, go to IDLE and set idx=0.
- load=1 in SEND sets overrun. The request is dropped and the frame register is not modified.
- abort=1 in any state has priority. Go to IDLE, set idx=0, and drop out_valid next cycle. A beat presented in that cycle counts as not delivered. A concurrent load is dropped and does not set overrun.
- overrun_clr=1 clears overrun. If overrun_clr and an overrun event occur in the same cycle, the set wins.
- Words are emitted in order 0..N-1. idx never wraps past N-1.
- Reset values: state IDLE, idx 0, out_valid 0, out_last 0, out_data 0, out_tag 0, load_ready 1, overrun 0, frame register 0.
- Reset asserted mid-frame: the frame is lost. Outputs take their reset values immediately (asynchronous).

## Timing
- Load accepted at edge t: out_valid=1 with word 0 from the cycle after t.
- With out_ready held high, words 0..N-1 appear on N consecutive cycles. out_last is high on the Nth. load_ready returns high the cycle after the last transfer.
- Frame period is N+1 cycles minimum. No back-to-back load in the last-beat cycle.
- While out_valid=1 and out_ready=0, out_data, out_tag and out_last hold stable.
- out_ready is ignored when out_valid=0.
- All outputs are registered or decoded from registered state only. No combinational path from out_ready to out_valid or out_data.
- Changing in_vec/in_sel after acceptance has no effect on the frame in flight.

## Structure
- Shared package vec16_pkg:
  - WIDTH=32, N=16, IDX_W=$clog2(N)
  - state enum {IDLE, SEND}
  - TAG_FLOAT=1'b0, TAG_SIGNED=1'b1
- One natural sub-module: vec16_frame_reg. It is the N×WIDTH capture register with load enable and an index read port, for reuse by the future deserializer on the input side.
- FSM, idx counter and overrun flag are inline in vec16_serializer.

## Test plan
- Reset, then load with word k = 32'h1000_0000+k and in_sel=1, out_ready=1. Required: 16 beats on consecutive cycles, data 10000000..1000000F, out_tag=1, out_last only on beat 15, load_ready high the cycle after.
- Same frame with out_ready toggling 1,0,0,1,… Required: each word held stable during stalls, no word skipped or duplicated, total of 16 transfers.
- load pulsed at beat 5 with a different in_vec. Required: overrun=1, remaining beats still from the original frame. overrun_clr then clears it. clr and a new overrun in the same cycle leave overrun=1.
- abort at beat 7 with load also high. Required: out_valid=0 next cycle, state IDLE, overrun stays 0. A fresh load then starts at word 0.
- rst_n asserted low asynchronously mid-frame, between clock edges. Required: out_valid, out_last and out_data reach 0 without waiting for a clock edge, and load_ready goes to 1. After release, a normal 16-word frame completes.
